// File: rtl/seven_seg_digit_scanner.sv
// Multiplexed seven-segment digit scanner with a shadow-buffered value and blank guards.
// Define SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN to darken leading zero digits.
module seven_seg_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              numeral_bit,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ?
                        REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam state_e ENTRY = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   active_q, active_d;
  logic            pending_q, pending_d;
  logic [3:0]      num_d;
  logic [NUM_DIGITS-1:0] sel_d;
  logic            start;
  logic            wrap;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ENTRY;
          idx_d   = '0;
          cnt_d   = '0;
          start   = 1'b1;
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ENTRY;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
              start = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame start promotes the pre-edge shadow; a coincident load stays pending.
  always_comb begin
    shadow_d  = load ? digits_in : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (start && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) pending_d = 1'b1;
  end

`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] upper_zero;
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc           = acc && (active_d[4*k +: 4] == 4'h0);
      upper_zero[k] = acc;
    end
  end
`endif

  always_comb begin
    num_d = 4'h0;
    sel_d = '0;
    if (state_d != IDLE) num_d = active_d[{idx_d, 2'b00} +: 4];
    if (state_d == SHOW) sel_d = NUM_DIGITS'(1) << idx_d;
`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
    if (idx_d != '0 && upper_zero[idx_d]) sel_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      numeral_bit <= 4'h0;
      digit_sel   <= '0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      numeral_bit <= num_d;
      digit_sel   <= sel_d;
      frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_scanner.sv
// Directed bench for seven_seg_digit_scanner (4 digits, dwell 3, blank 1).
// Expectations follow SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN when defined.
module tb_seven_seg_digit_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  numeral_bit;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int passed = 0;
  int total  = 0;

  seven_seg_digit_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (3),
    .BLANK_CYCLES(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .numeral_bit(numeral_bit),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame slot p: 4 cycles per digit, first one blank, then 3 lit.
  function automatic logic [7:0] exp_out(logic [15:0] v, int p);
    int d;
    logic [3:0] sel;
    logic [15:0] hi;
    d   = p / 4;
    sel = (p % 4 == 0) ? 4'b0000 : (4'b0001 << d);
    hi  = v >> (4 * d);
`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
    if (d > 0 && hi == 16'h0) sel = 4'b0000;
`endif
    return {sel, v[4*d +: 4]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++;
    if ({digit_sel, numeral_bit, frame_done} !== 9'h0)
      $display("FAIL reset: got sel=%b num=%h fd=%b, want 0/0/0",
               digit_sel, numeral_bit, frame_done);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if ({digit_sel, numeral_bit, frame_done} !== 9'h0)
        $display("FAIL idle c%0d: got sel=%b num=%h fd=%b, want 0/0/0",
                 i, digit_sel, numeral_bit, frame_done);
      else passed++;
    end
  endtask

  task automatic test_basic_scan();
    logic [7:0] e;
    digits_in = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    enable = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 16; p++) begin
        step();
        e = exp_out(16'h1234, p);
        total++;
        if ({digit_sel, numeral_bit} !== e || frame_done !== (p == 0 && f > 0))
          $display("FAIL scan f%0d p%0d: got sel=%b num=%h fd=%b, want sel=%b num=%h fd=%b",
                   f, p, digit_sel, numeral_bit, frame_done, e[7:4], e[3:0], (p == 0 && f > 0));
        else passed++;
      end
  endtask

  task automatic test_tear_free();
    logic [7:0] e;
    logic [15:0] v [4];
    v[0] = 16'h1234;
    v[1] = 16'hABCD;
    v[2] = 16'h5678;
    v[3] = 16'h9ABC;
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 16; p++) begin
        step();
        e = exp_out(v[f], p);
        total++;
        if ({digit_sel, numeral_bit} !== e || frame_done !== (p == 0))
          $display("FAIL tear f%0d p%0d: got sel=%b num=%h fd=%b, want sel=%b num=%h fd=%b",
                   f, p, digit_sel, numeral_bit, frame_done, e[7:4], e[3:0], (p == 0));
        else passed++;
        load = 1'b0;
        if (f == 0 && p == 9) begin
          digits_in = 16'hABCD;
          load = 1'b1;
        end
        if (f == 1 && p == 5) begin
          digits_in = 16'h5678;
          load = 1'b1;
        end
        if (f == 1 && p == 15) begin
          digits_in = 16'h9ABC;
          load = 1'b1;
        end
      end
  endtask

  task automatic test_enable_drop();
    logic [7:0] e;
    for (int p = 0; p < 6; p++) step();
    total++;
    if (digit_sel !== 4'b0010 || numeral_bit !== 4'hB)
      $display("FAIL drop_pre: got sel=%b num=%h, want sel=0010 num=b",
               digit_sel, numeral_bit);
    else passed++;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (digit_sel !== 4'b0000 || frame_done !== 1'b0)
        $display("FAIL drop c%0d: got sel=%b fd=%b, want sel=0000 fd=0",
                 i, digit_sel, frame_done);
      else passed++;
    end
    enable = 1'b1;
    for (int p = 0; p < 16; p++) begin
      step();
      e = exp_out(16'h9ABC, p);
      total++;
      if ({digit_sel, numeral_bit} !== e || frame_done !== 1'b0)
        $display("FAIL restart p%0d: got sel=%b num=%h fd=%b, want sel=%b num=%h fd=0",
                 p, digit_sel, numeral_bit, frame_done, e[7:4], e[3:0]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    for (int p = 0; p < 6; p++) step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({digit_sel, numeral_bit, frame_done} !== 9'h0)
      $display("FAIL async_rst: got sel=%b num=%h fd=%b, want 0/0/0",
               digit_sel, numeral_bit, frame_done);
    else passed++;
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 16; p++) begin
      step();
      e = exp_out(16'h0000, p);
      total++;
      if ({digit_sel, numeral_bit} !== e || frame_done !== 1'b0)
        $display("FAIL post_rst p%0d: got sel=%b num=%h fd=%b, want sel=%b num=%h fd=0",
                 p, digit_sel, numeral_bit, frame_done, e[7:4], e[3:0]);
      else passed++;
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] e;
    logic [15:0] v [2];
    v[0] = 16'h0050;
    v[1] = 16'h0000;
    for (int t = 0; t < 2; t++) begin
      enable = 1'b0;
      digits_in = v[t];
      load = 1'b1;
      step();
      load = 1'b0;
      enable = 1'b1;
      for (int p = 0; p < 16; p++) begin
        step();
        e = exp_out(v[t], p);
        total++;
        if ({digit_sel, numeral_bit} !== e)
          $display("FAIL lz v%h p%0d: got sel=%b num=%h, want sel=%b num=%h",
                   v[t], p, digit_sel, numeral_bit, e[7:4], e[3:0]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_enable_drop();
    test_async_reset();
    test_leading_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_digit_scanner.md
Name: seven_seg_digit_scanner

Overview:
- Upstream feeder for the single-digit seven-segment decoder.
- Holds a multi-digit BCD/hex value and time-multiplexes it onto one shared 4-bit nibble bus (numeral_bit) plus a one-hot digit-select (anode) bus.
- Double-buffers the displayed value so updates only take effect at frame boundaries, which prevents a partially updated (torn) display.
- Inserts a blanking guard between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; must be >= 2.
- REFRESH_DIV, 50000: clock cycles each digit is lit (SHOW dwell); must be >= 1.
- BLANK_CYCLES, 2: guard cycles with all digit selects off before each digit; 0 means no BLANK state.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: scanning enable; low means the display is dark.
- load, input, 1: single-cycle strobe that captures digits_in into the shadow register.
- digits_in, input, 4*NUM_DIGITS: digit value; digit k is digits_in[4k+3:4k], and digit 0 is least significant.
- numeral_bit, output, 4: nibble for the current digit; drives the decoder input.
- digit_sel, output, NUM_DIGITS: one-hot, active-high select; bit k lights digit k.
- frame_done, output, 1: one-cycle pulse at the end of the last digit's SHOW slot.

Behaviour:
Registers and reset:
- All outputs are registered.
- While rst_n is low: numeral_bit=0, digit_sel=0, frame_done=0, state=IDLE, idx=0, dwell counter=0, shadow=0, active=0, pending=0.
- Reset acts immediately, including in the middle of a frame.

Load path:
- load=1 captures shadow<=digits_in and sets pending=1.
- Load is independent of enable and state.
- A load while pending=1 overwrites shadow; pending stays 1.

States: IDLE, BLANK, SHOW.

IDLE:
- digit_sel=0, idx=0, counter=0.
- On a clock edge with enable=1, go to BLANK (or SHOW if BLANK_CYCLES=0) for idx 0. This is a frame start.

Frame start (IDLE exit, or wrap from the last digit):
- If pending=1: active<=shadow, pending<=0.
- The transfer uses the pre-edge shadow value.
- A load in the same cycle updates shadow and leaves pending=1 for the next frame.

BLANK:
- digit_sel=0.
- numeral_bit already holds active[idx] so the decoder settles before the digit lights.
- Lasts BLANK_CYCLES cycles, then goes to SHOW.

SHOW:
- digit_sel=(1<<idx), numeral_bit=active[idx].
- Lasts REFRESH_DIV cycles.
- If idx<NUM_DIGITS-1, then idx+1 and go to BLANK.
- Otherwise frame_done=1 for exactly one cycle (registered with the transition), idx wraps to 0, a frame start occurs, and go to BLANK.

Timing:
- Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- The dwell counter is wide enough for max(REFRESH_DIV, BLANK_CYCLES) and never wraps mid-slot.

enable deasserted in any state:
- Next edge goes to IDLE with digit_sel=0 and frame_done=0.
- idx and counter clear; shadow and pending are preserved.
- No frame_done is produced for an aborted frame.

Invariants:
- digit_sel is never more than one-hot.
- digit_sel is never nonzero in IDLE or BLANK.

Optional Feature:
Macro: SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN

When defined:
- In SHOW for idx>0, digit_sel is forced to 0 if active[idx] and every higher digit are all 0.
- Digit 0 is always lit.
- Timing, numeral_bit and frame_done are unchanged, so the slot still elapses dark.

When undefined:
- All digits are lit in their slots, including leading zeros.

Test Plan:
1. Reset and idle: hold rst_n=0, then release with enable=0 for 20 cycles -> numeral_bit=0, digit_sel=0, frame_done=0 throughout.
2. Basic scan (NUM_DIGITS=4, REFRESH_DIV=3, BLANK_CYCLES=1): load 0x1234, then enable=1 -> repeating pattern {0000 for 1 cycle, 0001 with numeral 4 for 3 cycles, 0000, 0010 with numeral 3 for 3, 0000, 0100 with numeral 2 for 3, 0000, 1000 with numeral 1 for 3}. frame_done pulses once per 16 cycles, coincident with the wrap.
3. Tear-free update: load 0xABCD while digit 2 is lit -> digits 2 and 3 of the current frame still show 2 and 1; the next frame shows D, C, B, A. Also load on the exact wrap cycle -> that frame shows the previously pending value and the new value appears one frame later.
4. enable dropped mid-SHOW of digit 1 -> next cycle digit_sel=0 with no frame_done. Re-enable -> scan restarts at digit 0, preceded by a BLANK cycle.
5. Async reset asserted mid-SHOW, between clock edges -> digit_sel=0 and numeral_bit=0 immediately. After release with enable=1, the display shows 0000 until a load.
6. With SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN defined, load 0x0050 -> digits 3 and 2 are dark, digit 1 shows 5, digit 0 shows 0. Load 0x0000 -> only digit 0 is lit, showing 0.
